// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum byte).
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Assembles a little-endian 32-bit word from a byte stream. word_done flags
// the cycle in which the final byte of a word is being accepted.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] byte_idx;

    // Shifting in from the top leaves the first byte in [7:0] after four shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {data, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word_done = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: header (16-bit word count, LE) then words written to IM.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after the image).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IM_DEPTH = 1024,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t      state, state_nxt;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [15:0] hdr_count;
    logic [31:0] word;
    logic        word_done;
    logic        xfer;
    logic        start_ok;
    logic        last_word;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_FIN = ST_CSUM;
    logic [7:0] csum;
`else
    localparam state_t ST_FIN = ST_DONE;
`endif

    assign xfer      = rx_valid && rx_ready;
    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign hdr_count = {rx_data, count[7:0]};
    assign last_word = (16'(word_idx + 16'd1) == count);

    word_assembler u_asm (
        .clk       (CLK),
        .rst_n     (reset),
        .clear     (start_ok),
        .shift_en  (xfer && state == ST_DATA),
        .data      (rx_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_HDR0;
            ST_HDR0: if (xfer) state_nxt = ST_HDR1;
            ST_HDR1: if (xfer) begin
                if (hdr_count > 16'(IM_DEPTH)) state_nxt = ST_ERR;
                else if (hdr_count == 16'd0)   state_nxt = ST_FIN;
                else                           state_nxt = ST_DATA;
            end
            ST_DATA:  if (word_done) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_word ? ST_FIN : ST_DATA;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM:  if (xfer) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
`endif
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ready    = (state == ST_HDR0) || (state == ST_HDR1) ||
                      (state == ST_DATA) || (state == ST_CSUM);
        im_we       = (state == ST_WRITE);
        busy        = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_DATA) ||
                      (state == ST_WRITE) || (state == ST_CSUM);
        done        = (state == ST_DONE);
        err         = (state == ST_ERR);
        cpu_reset_n = (state == ST_DONE);
        im_addr     = ADDR_W'(word_idx) << 2;
        im_wdata    = word;
    end

    // Header count, word index and running checksum.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            word_idx <= '0;
        end else if (start_ok) begin
            word_idx <= '0;
        end else begin
            if (state == ST_HDR0 && xfer) count[7:0]  <= rx_data;
            if (state == ST_HDR1 && xfer) count[15:8] <= rx_data;
            if (state == ST_WRITE)        word_idx    <= word_idx + 16'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                         csum <= '0;
        else if (start_ok)                  csum <= '0;
        else if (state == ST_DATA && xfer)  csum <= csum ^ rx_data;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (checksum steps under LOADER_CHECKSUM_EN).
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        err;

    int tests  = 0;
    int failed = 0;

    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic        wr_rdy  [64];
    int          nw = 0;

    prog_loader #(.IM_DEPTH(1024), .ADDR_W(32)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (im_we && nw < 64) begin
            wr_addr[nw] = im_addr;
            wr_data[nw] = im_wdata;
            wr_rdy[nw]  = rx_ready;
            nw = nw + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n = 0;
        @(negedge CLK);
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge CLK);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge CLK);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_image2(input bit gap);
        send(8'h02, gap); send(8'h00, gap);
        send(8'h13, gap); send(8'h05, gap); send(8'hA0, gap); send(8'h00, gap);
        send(8'h93, gap); send(8'h05, gap); send(8'h10, gap); send(8'h00, gap);
`ifdef LOADER_CHECKSUM_EN
        send(8'h30, gap);
`endif
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || err) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) check("end_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_image2(input string tag, input int base);
        check({tag, "_nwr"},   32'(nw - base), 32'd2);
        check({tag, "_addr0"}, wr_addr[base],     32'h0);
        check({tag, "_data0"}, wr_data[base],     32'h00A00513);
        check({tag, "_addr1"}, wr_addr[base + 1], 32'h4);
        check({tag, "_data1"}, wr_data[base + 1], 32'h00100593);
        check({tag, "_done"},  32'(done),        32'd1);
        check({tag, "_cpurst"},32'(cpu_reset_n), 32'd1);
        check({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   32'(rx_ready),    32'd0);
        check({tag, "_we"},    32'(im_we),       32'd0);
        check({tag, "_addr"},  im_addr,          32'd0);
        check({tag, "_wdata"}, im_wdata,         32'd0);
        check({tag, "_cpurst"},32'(cpu_reset_n), 32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_done"},  32'(done),        32'd0);
        check({tag, "_err"},   32'(err),         32'd0);
    endtask

    initial begin
        int base;
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge CLK);
        check_reset_vals("idle");

        // Bytes offered in IDLE must not be taken.
        rx_valid = 1'b1; rx_data = 8'h5A;
        repeat (3) begin
            @(negedge CLK);
            check("idle_rdy", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        check("idle_nwr", 32'(nw), 32'd0);

        // Two-word image, back-to-back bytes.
        base = nw;
        pulse_start();
        check("hdr0_busy", 32'(busy), 32'd1);
        check("hdr0_rdy",  32'(rx_ready), 32'd1);
        send_image2(1'b0);
        wait_end();
        check_image2("img", base);
        check("img_wr_rdy0", 32'(wr_rdy[base]), 32'd0);

        // Empty image.
        base = nw;
        pulse_start();
        send(8'h00, 1'b0); send(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00, 1'b0);
`endif
        wait_end();
        check("zero_done",   32'(done), 32'd1);
        check("zero_cpurst", 32'(cpu_reset_n), 32'd1);
        repeat (2) @(negedge CLK);
        check("zero_nwr", 32'(nw - base), 32'd0);

        // Count 1025 exceeds capacity.
        base = nw;
        pulse_start();
        send(8'h01, 1'b0); send(8'h04, 1'b0);
        wait_end();
        check("ovf_err",    32'(err), 32'd1);
        check("ovf_done",   32'(done), 32'd0);
        check("ovf_cpurst", 32'(cpu_reset_n), 32'd0);
        check("ovf_rdy",    32'(rx_ready), 32'd0);
        repeat (2) @(negedge CLK);
        check("ovf_nwr", 32'(nw - base), 32'd0);

        // rx_valid toggling during the load.
        base = nw;
        pulse_start();
        send_image2(1'b1);
        wait_end();
        check_image2("tgl", base);
        check("tgl_wr_rdy0", 32'(wr_rdy[base]),     32'd0);
        check("tgl_wr_rdy1", 32'(wr_rdy[base + 1]), 32'd0);

        // Reset after 5 data bytes, then a clean reload.
        pulse_start();
        send(8'h02, 1'b0); send(8'h00, 1'b0);
        send(8'h13, 1'b0); send(8'h05, 1'b0); send(8'hA0, 1'b0); send(8'h00, 1'b0);
        send(8'h93, 1'b0);
        @(negedge CLK);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge CLK);
        reset = 1'b1;
        base = nw;
        pulse_start();
        send_image2(1'b0);
        wait_end();
        check_image2("reload", base);

`ifdef LOADER_CHECKSUM_EN
        base = nw;
        pulse_start();
        send(8'h01, 1'b0); send(8'h00, 1'b0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'h44, 1'b0);
        wait_end();
        check("cs_ok_done",  32'(done), 32'd1);
        check("cs_ok_data",  wr_data[base], 32'h44332211);
        pulse_start();
        send(8'h01, 1'b0); send(8'h00, 1'b0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'h45, 1'b0);
        wait_end();
        check("cs_bad_err",    32'(err), 32'd1);
        check("cs_bad_cpurst", 32'(cpu_reset_n), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
